// File: rtl/store_buffer_if.sv
// Store-request and memory-drain signal bundle for store_buffer.
// slave is the buffer itself; master is whoever issues stores and services memory.
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  modport master (
    output st_valid, st_size, st_addr, st_data, mem_ready,
    input  st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  st_valid, st_size, st_addr, st_data, mem_ready,
    output st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_buffer.sv
// Store write buffer: formats sb/sh/sw onto byte lanes, rejects misaligned/reserved stores,
// and queues accepted stores in a DEPTH-entry FIFO drained over a valid/ready handshake.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q;

  logic [31:0] addr_q  [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic [3:0]  be_q    [DEPTH];

  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic        bad;
  logic        full, accept, enq, deq;

  // Lane formatting; bad marks stores that complete the handshake but are dropped.
  always_comb begin
    lane_wdata = '0;
    lane_be    = '0;
    bad        = 1'b0;
    case (bus.st_size)
      2'b00: begin
        lane_wdata = {4{bus.st_data[7:0]}};
        lane_be    = 4'b0001 << bus.st_addr[1:0];
      end
      2'b01: begin
        bad        = bus.st_addr[0];
        lane_wdata = {2{bus.st_data[15:0]}};
        lane_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        bad        = |bus.st_addr[1:0];
        lane_wdata = bus.st_data;
        lane_be    = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
  end

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign bus.st_ready = !full;
  assign bus.st_err   = err_q;
  assign accept       = bus.st_valid && !full;
  assign enq          = accept && !bad;
  assign deq          = !empty && bus.mem_ready;

  assign bus.mem_valid = !empty;
  assign bus.mem_addr  = empty ? '0 : addr_q[head_q];
  assign bus.mem_wdata = empty ? '0 : wdata_q[head_q];
  assign bus.mem_be    = empty ? '0 : be_q[head_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PW'(1);
    if (deq) head_d = head_q + PW'(1);
    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= accept && bad;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q]  <= {bus.st_addr[31:2], 2'b00};
      wdata_q[tail_q] <= lane_wdata;
      be_q[tail_q]    <= lane_be;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a random soak,
// all compared every cycle against a queue-based reference model.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          empty;
  logic [CW-1:0] count;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .empty (empty),
    .count (count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t exp_q[$];
  logic exp_err  = 1'b0;
  logic last_acc = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic ent_t fmt(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    ent_t        e;
    int unsigned lane;
    lane   = a % 4;
    e.addr = a - lane;
    if (sz == 2'd0) begin
      e.wdata = 32'(d[7:0]) * 32'h0101_0101;
      e.be    = 4'(1 << lane);
    end else if (sz == 2'd1) begin
      e.wdata = 32'(d[15:0]) * 32'h0001_0001;
      e.be    = 4'(3 << lane);
    end else begin
      e.wdata = d;
      e.be    = 4'hf;
    end
    return e;
  endfunction

  // Compare all outputs at the negedge, then advance the model by one clock.
  task automatic step();
    ent_t head;
    logic acc;
    logic drain;
    @(negedge clk);
    head = exp_q.size() > 0 ? exp_q[0] : '0;
    check_eq("st_ready", 32'(bus.st_ready), 32'(exp_q.size() < DEPTH));
    check_eq("st_err", 32'(bus.st_err), 32'(exp_err));
    check_eq("mem_valid", 32'(bus.mem_valid), 32'(exp_q.size() > 0));
    check_eq("mem_addr", bus.mem_addr, head.addr);
    check_eq("mem_wdata", bus.mem_wdata, head.wdata);
    check_eq("mem_be", 32'(bus.mem_be), 32'(head.be));
    check_eq("empty", 32'(empty), 32'(exp_q.size() == 0));
    check_eq("count", 32'(count), 32'(exp_q.size()));
    if (reset) begin
      exp_q.delete();
      exp_err  = 1'b0;
      last_acc = 1'b0;
    end else begin
      acc   = bus.st_valid && (exp_q.size() < DEPTH);
      drain = (exp_q.size() > 0) && bus.mem_ready;
      if (drain) void'(exp_q.pop_front());
      exp_err = acc && is_bad(bus.st_size, bus.st_addr);
      if (acc && !is_bad(bus.st_size, bus.st_addr)) begin
        exp_q.push_back(fmt(bus.st_size, bus.st_addr, bus.st_data));
      end
      last_acc = acc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_size  = sz;
    bus.st_addr  = a;
    bus.st_data  = d;
    for (int i = 0; i < 32; i++) begin
      step();
      if (last_acc) break;
    end
    check_eq("offer_accepted", 32'(last_acc), 32'd1);
    bus.st_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.st_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.st_valid  = 1'b0;
    bus.st_size   = 2'd0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    idle(2);

    // Byte lanes, draining freely.
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(2'd0, 32'h1000 + 32'(i), 32'hDEAD_BEEF);
      #3;
      check_eq("sb_wdata", bus.mem_wdata, 32'hEFEF_EFEF);
      check_eq("sb_be", 32'(bus.mem_be), 32'(1 << i));
    end
    idle(2);

    // Halfword and word.
    offer(2'd1, 32'h2002, 32'h1234_5678);
    #3;
    check_eq("sh_wdata", bus.mem_wdata, 32'h5678_5678);
    check_eq("sh_be", 32'(bus.mem_be), 32'hc);
    offer(2'd2, 32'h2004, 32'h1234_5678);
    #3;
    check_eq("sw_addr", bus.mem_addr, 32'h2004);
    idle(2);

    // Error requests, including back-to-back.
    offer(2'd1, 32'h2001, 32'h1);
    offer(2'd2, 32'h2002, 32'h2);
    offer(2'd3, 32'h2000, 32'h3);
    #3;
    check_eq("err_pulse", 32'(bus.st_err), 32'd1);
    check_eq("err_count", 32'(count), 32'd0);
    idle(2);

    // Fill and stall; fifth store waits until memory resumes.
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(2'd2, 32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    #3;
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_ready", 32'(bus.st_ready), 32'd0);
    fork
      offer(2'd2, 32'h3010, 32'hA000_0004);
      begin
        repeat (4) @(posedge clk);
        #2;
        bus.mem_ready = 1'b1;
      end
    join
    idle(6);

    // count == 1 with simultaneous enqueue and dequeue.
    bus.mem_ready = 1'b0;
    offer(2'd2, 32'h4000, 32'h1111_1111);
    bus.mem_ready = 1'b1;
    offer(2'd2, 32'h4004, 32'h2222_2222);
    #3;
    check_eq("simul_count", 32'(count), 32'd1);
    check_eq("simul_head", bus.mem_addr, 32'h4004);
    idle(2);

    // Reset mid-operation with a stalled head.
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer(2'd0, 32'h5000 + 32'(i), 32'h55 + 32'(i));
    reset = 1'b1;
    step();
    reset = 1'b0;
    #3;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_valid", 32'(bus.mem_valid), 32'd0);
    bus.mem_ready = 1'b1;
    idle(4);

    // Random soak.
    for (int i = 0; i < 2000; i++) begin
      bus.st_valid  = ($urandom_range(0, 3) != 0);
      bus.st_size   = 2'($urandom_range(0, 3));
      bus.st_addr   = $urandom;
      bus.st_data   = $urandom;
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    bus.mem_ready = 1'b1;
    idle(DEPTH + 2);
    check_eq("soak_drained", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
